// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by
// defining the macro MDU_MADD_EN; otherwise those opcodes behave as NONE.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hilo_rd,
  output logic [31:0] hilo_out
);

  localparam int unsigned MULT_N     = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
  localparam int unsigned DIV_N      = (DIV_CYCLES < 1) ? 1 : DIV_CYCLES;
  localparam int unsigned MAX_N      = (MULT_N > DIV_N) ? MULT_N : DIV_N;
  localparam int unsigned CNT_W      = $clog2(MAX_N + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        res_q, res_d;
  logic [31:0]        hi_d, lo_d;
  logic               busy_d;

  logic signed [63:0] rs_sx, rt_sx;
  logic signed [31:0] rs_s, rt_s;
  logic [63:0]        prod_s, prod_u, div_s, div_u;
  logic               launch;
  logic [63:0]        launch_res;
  logic [CNT_W-1:0]   launch_cnt;

  assign rs_s  = rs_val;
  assign rt_s  = rt_val;
  assign rs_sx = {{32{rs_val[31]}}, rs_val};
  assign rt_sx = {{32{rt_val[31]}}, rt_val};

  // Full-width signed and unsigned products of the live operands
  always_comb begin
    prod_s = 64'(rs_sx * rt_sx);
    prod_u = 64'({32'd0, rs_val} * {32'd0, rt_val});
  end

  // Quotient/remainder with divide-by-zero and signed-overflow results fixed up front
  always_comb begin
    if (rt_val == 32'd0) begin
      div_s = {rs_val, 32'hFFFF_FFFF};
      div_u = {rs_val, 32'hFFFF_FFFF};
    end else begin
      div_u = {rs_val % rt_val, rs_val / rt_val};
      if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
        div_s = {32'd0, 32'h8000_0000};
      end else begin
        div_s = {32'(rs_s % rt_s), 32'(rs_s / rt_s)};
      end
    end
  end

  // Decode which ops launch a multi-cycle run, with their result and latency
  always_comb begin
    launch     = 1'b0;
    launch_res = 64'd0;
    launch_cnt = '0;
    case (md_op)
      OP_MULT:  begin launch = 1'b1; launch_res = prod_s; launch_cnt = CNT_W'(MULT_N); end
      OP_MULTU: begin launch = 1'b1; launch_res = prod_u; launch_cnt = CNT_W'(MULT_N); end
      OP_DIV:   begin launch = 1'b1; launch_res = div_s;  launch_cnt = CNT_W'(DIV_N);  end
      OP_DIVU:  begin launch = 1'b1; launch_res = div_u;  launch_cnt = CNT_W'(DIV_N);  end
`ifdef MDU_MADD_EN
      OP_MADD:  begin launch = 1'b1; launch_res = {hi, lo} + prod_s; launch_cnt = CNT_W'(MULT_N); end
      OP_MADDU: begin launch = 1'b1; launch_res = {hi, lo} + prod_u; launch_cnt = CNT_W'(MULT_N); end
      OP_MSUB:  begin launch = 1'b1; launch_res = {hi, lo} - prod_s; launch_cnt = CNT_W'(MULT_N); end
      OP_MSUBU: begin launch = 1'b1; launch_res = {hi, lo} - prod_u; launch_cnt = CNT_W'(MULT_N); end
`endif
      default: ;
    endcase
  end

  // Next-state logic: accept in IDLE, count down in RUN, commit HI/LO on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi;
    lo_d    = lo;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (launch) begin
            state_d = RUN;
            cnt_d   = launch_cnt;
            res_d   = launch_res;
          end else if (md_op == OP_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == OP_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= 64'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi      <= hi_d;
      lo      <= lo_d;
      busy    <= busy_d;
    end
  end

  // Zero-latency MFHI/MFLO read path
  assign hilo_rd  = start & ((md_op == OP_MFHI) | (md_op == OP_MFLO));
  assign hilo_out = (md_op == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit; honours MDU_MADD_EN when defined.
module tb_md_unit;
  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        busy, hilo_rd;
  logic [31:0] hi, lo, hilo_out;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo),
    .hilo_rd(hilo_rd), .hilo_out(hilo_out)
  );

  // Architectural result of an op given current HI:LO, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
    longint sa, sb;
    longint unsigned ua, ub, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {h, l};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            else return {32'(ua % ub), 32'(ua / ub)};
      4'd5: return {a, l};
      4'd6: return {h, a};
`ifdef MDU_MADD_EN
      4'd9:  return acc + 64'(sa * sb);
      4'd10: return acc + ua * ub;
      4'd11: return acc - 64'(sa * sb);
      4'd12: return acc - ua * ub;
`endif
      default: return acc;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MULT_N;
      4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: return MULT_N;
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op at the current negedge, check busy/HI/LO every cycle until done,
  // then probe MFHI/MFLO; returns at the first negedge with busy low.
  task automatic exec_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit pulse_mid, input string name);
    int n;
    logic [63:0] r;
    n = ref_cycles(op);
    r = ref_result(op, a, b, hi_m, lo_m);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s accept_busy: got %b want 0", name, busy);
    end
    @(negedge clk);
    start = 1'b0; md_op = 4'($urandom_range(0, 12)); rs_val = $urandom; rt_val = $urandom;
    for (int j = 1; j <= n; j++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || hi !== hi_m || lo !== lo_m) begin
        errors++;
        $display("FAIL %s run_cycle%0d: busy=%b hi=%h lo=%h want busy=1 hi=%h lo=%h",
                 name, j, busy, hi, lo, hi_m, lo_m);
      end
      if (pulse_mid && j == 3) begin
        start = 1'b1; md_op = 4'd1; rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    hi_m = r[63:32];
    lo_m = r[31:0];
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
      errors++;
      $display("FAIL %s done: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
               name, busy, hi, lo, hi_m, lo_m);
    end
    start = 1'b1; md_op = 4'd7;
    #1;
    checks++;
    if (hilo_rd !== 1'b1 || hilo_out !== hi_m) begin
      errors++; $display("FAIL %s mfhi: rd=%b out=%h want rd=1 out=%h", name, hilo_rd, hilo_out, hi_m);
    end
    md_op = 4'd8;
    #1;
    checks++;
    if (hilo_rd !== 1'b1 || hilo_out !== lo_m) begin
      errors++; $display("FAIL %s mflo: rd=%b out=%h want rd=1 out=%h", name, hilo_rd, hilo_out, lo_m);
    end
    start = 1'b0; md_op = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || hilo_rd !== 1'b0) begin
      errors++; $display("FAIL reset: busy=%b hi=%h lo=%h rd=%b want 0", busy, hi, lo, hilo_rd);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    exec_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_neg2x3");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_const: hi=%h lo=%h want ffffffff fffffffa", hi, lo);
    end
    exec_op(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu_neg2x3");
    checks++;
    if (hi !== 32'd2 || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL multu_const: hi=%h lo=%h want 00000002 fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    exec_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_const: hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    end
    exec_op(4'd4, 32'd7, 32'd0, 1'b0, "divu_by0");
    checks++;
    if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin
      errors++; $display("FAIL divu0_const: hi=%h lo=%h want 00000007 ffffffff", hi, lo);
    end
    exec_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++; $display("FAIL divovf_const: hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
    exec_op(4'd3, 32'd100, 32'd0, 1'b0, "div_by0");
    exec_op(4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
  endtask

  task automatic test_mthi_mfhi();
    exec_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, "mthi");
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi_const: hi=%h want 12345678", hi);
    end
    exec_op(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0, "mfhi_nochange");
    exec_op(4'd6, 32'hCAFE_F00D, 32'd0, 1'b0, "mtlo");
    exec_op(4'd0, 32'h1111_1111, 32'd0, 1'b0, "none");
  endtask

  task automatic test_ignore_in_run();
    exec_op(4'd3, 32'd1000, 32'd7, 1'b1, "div_with_mult_pulse");
  endtask

  task automatic test_madd();
    exec_op(4'd5, 32'd0, 32'd0, 1'b0, "madd_set_hi");
    exec_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_set_lo");
    exec_op(4'd10, 32'd1, 32'd1, 1'b0, "maddu_1x1");
    checks++;
`ifdef MDU_MADD_EN
    if (hi !== 32'd1 || lo !== 32'd0) begin
      errors++; $display("FAIL maddu_const: hi=%h lo=%h want 00000001 00000000", hi, lo);
    end
`else
    if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL maddu_off_const: hi=%h lo=%h want 00000000 ffffffff", hi, lo);
    end
`endif
    exec_op(4'd9, 32'hFFFF_FFFD, 32'd5, 1'b0, "madd_neg");
    exec_op(4'd11, 32'h0001_0000, 32'h0002_0000, 1'b0, "msub");
    exec_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "msubu");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 12));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      exec_op(op, a, b, 1'b0, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  task automatic test_reset_mid_run();
    exec_op(4'd5, 32'hA5A5_A5A5, 32'd0, 1'b0, "pre_reset_hi");
    exec_op(4'd6, 32'h5A5A_5A5A, 32'd0, 1'b0, "pre_reset_lo");
    start = 1'b1; md_op = 4'd3; rs_val = 32'd12345; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_mid_run: busy=%b hi=%h lo=%h want 0", busy, hi, lo);
    end
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++; $display("FAIL no_late_write%0d: busy=%b hi=%h lo=%h want 0", j, busy, hi, lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mfhi();
    test_ignore_in_run();
    test_madd();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
